// File: rtl/pipelined_shifter.sv
// Purpose: pipelined SLL/SRL/SRA/ROL/ROR on an XLEN-bit operand, with a sideband tag carried alongside.
// Latency: STAGES cycles; the log2(XLEN) shift levels are spread evenly across the register stages.
// Backpressure: valid/ready per stage; in_ready is combinational from out_ready, so there are no bubbles.
module pipelined_shifter #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_data,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int LVLS = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [LVLS-1:0]  shamt;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t             src_s [STAGES];
    stage_t             stg_d [STAGES];
    stage_t             stg_q [STAGES];
    logic [STAGES-1:0]  vld_q;
    logic [STAGES-1:0]  vld_src;
    logic [STAGES-1:0]  load;
    logic               accept;

    // One shift level by a fixed power of two. SRA fills with the current MSB, which
    // always equals the original operand MSB because earlier levels also sign-filled.
    function automatic logic [XLEN-1:0] lvl(input logic [XLEN-1:0] d,
                                            input logic [2:0]      op,
                                            input int              sh);
        logic [XLEN-1:0] r;
        case (op)
            3'b000:  r = d << sh;
            3'b001:  r = d >> sh;
            3'b011:  r = $unsigned($signed(d) >>> sh);
            3'b100:  r = (d << sh) | (d >> (XLEN - sh));
            3'b101:  r = (d >> sh) | (d << (XLEN - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    // A stage loads when every stage from it to the output is either empty or the output drains.
    always_comb begin
        logic acc;
        acc  = out_ready;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc || !vld_q[k];
            load[k] = acc;
        end
    end

    assign in_ready = rst_n && !flush && load[0];
    assign accept   = in_valid && in_ready;

    // Source of each stage: the input port for stage 0, the previous register otherwise.
    always_comb begin
        src_s[0]   = '{data: in_data, shamt: in_shamt, op: in_op, tag: in_tag};
        vld_src[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            src_s[k]   = stg_q[k-1];
            vld_src[k] = vld_q[k-1];
        end
    end

    // Apply the shift levels owned by each stage: level j lives in stage floor(j*STAGES/LVLS).
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg_d[k] = src_s[k];
            for (int j = 0; j < LVLS; j++) begin
                if (((j * STAGES) / LVLS) == k && src_s[k].shamt[j])
                    stg_d[k].data = lvl(stg_d[k].data, src_s[k].op, 1 << j);
            end
        end
    end

    // Valid bits: cleared by reset or flush, otherwise shifted forward wherever a stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (load[k]) vld_q[k] <= vld_src[k];
        end
    end

    // Payload registers: only move on load, so a stalled output holds its data and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (load[k]) stg_q[k] <= stg_d[k];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = stg_q[STAGES-1].data;
    assign out_tag   = stg_q[STAGES-1].tag;

    // The last stage's shift amount and op have no consumer after the final level.
    logic unused_last;
    assign unused_last = ^{stg_q[STAGES-1].shamt, stg_q[STAGES-1].op};

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_data;
    logic [4:0]        in_shamt;
    logic [2:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [TAG_W-1:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    pipelined_shifter #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit-at-a-time reference shifter.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d,
                                          input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                3'b000:  r = {r[30:0], 1'b0};
                3'b001:  r = {1'b0, r[31:1]};
                3'b011:  r = {r[31], r[31:1]};
                3'b100:  r = {r[30:0], r[31]};
                3'b101:  r = {r[0], r[31:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [4:0] tg);
        in_op = op; in_data = d; in_shamt = sh; in_tag = tg; in_valid = 1'b1;
    endtask

    // Issue one op unstalled; report result, tag and edges from acceptance to out_valid.
    task automatic run_one(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                           input logic [4:0] tg, output logic [31:0] res,
                           output logic [4:0] rtag, output int lat);
        int n;
        out_ready = 1'b1;
        drive(op, d, sh, tg);
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        step();
        in_valid = 1'b0;
        res = '0; rtag = '0; lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                res = out_data; rtag = out_tag; lat = c;
                break;
            end
            step();
        end
        if (lat >= 0) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_sra_latency();
        out_ready = 1'b1;
        drive(3'b011, 32'h8000_0000, 5'd4, 5'd3);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sra_early_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sra_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hF800_0000) begin failures++; $display("FAIL sra_data got=%h exp=f8000000", out_data); end
        checks++; if (out_tag !== 5'd3) begin failures++; $display("FAIL sra_tag got=%0d exp=3", out_tag); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sra_valid_once got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
        logic [31:0] ins [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001};
        logic [4:0]  shs [4] = '{5'd31, 5'd31, 5'd1, 5'd1};
        logic [31:0] exp [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0003, 32'h8000_0000};
        int rcv = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                drive(ops[c], ins[c], shs[c], 5'(20 + c));
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready op=%0d got=%b exp=1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid) begin
                if (rcv < 4) begin
                    checks++; if (out_data !== exp[rcv]) begin failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", rcv, out_data, exp[rcv]); end
                    checks++; if (out_tag !== 5'(20 + rcv)) begin failures++; $display("FAIL b2b_tag idx=%0d got=%0d exp=%0d", rcv, out_tag, 20 + rcv); end
                end
                if (first < 0) first = c;
                last = c;
                rcv++;
            end
        end
        checks++; if (rcv !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", rcv); end
        checks++; if (first !== STAGES - 1) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=%0d", first, STAGES - 1); end
        checks++; if (last !== first + 3) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=%0d", last, first + 3); end
    endtask

    task automatic test_backpressure();
        logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b101};
        logic [31:0] ins [3] = '{32'h0000_0001, 32'h0000_00F0, 32'h0000_0001};
        logic [31:0] exp [3] = '{32'h0000_0010, 32'h0000_000F, 32'h1000_0000};
        int idx = 0, rcv = 0;
        logic acc;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(ops[idx], ins[idx], 5'd4, 5'(10 + idx));
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
            if (c >= 3) begin
                checks++; if (out_data !== exp[0] || out_tag !== 5'd10) begin failures++; $display("FAIL bp_stable got=%h/%0d exp=%h/10", out_data, out_tag, exp[0]); end
            end
        end
        checks++; if (idx !== STAGES) begin failures++; $display("FAIL bp_accepts got=%0d exp=%0d", idx, STAGES); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (idx < 3) drive(ops[idx], ins[idx], 5'd4, 5'(10 + idx));
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (rcv < 3) begin
                    checks++; if (out_data !== exp[rcv] || out_tag !== 5'(10 + rcv)) begin failures++; $display("FAIL bp_drain idx=%0d got=%h/%0d exp=%h/%0d", rcv, out_data, out_tag, exp[rcv], 10 + rcv); end
                end
                rcv++;
            end
            step();
            if (acc) idx++;
        end
        checks++; if (rcv !== 3) begin failures++; $display("FAIL bp_drain_count got=%0d exp=3", rcv); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(3'b000, 32'h0000_0001, 5'd1, 5'd1);
        step();
        drive(3'b000, 32'h0000_0001, 5'd2, 5'd2);
        step();
        drive(3'b000, 32'h0000_0001, 5'd3, 5'd3);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            step();
        end
        drive(3'b001, 32'hFFFF_FFFF, 5'd8, 5'd7);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_flush_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h00FF_FFFF) begin failures++; $display("FAIL post_flush_data got=%h exp=00ffffff", out_data); end
        checks++; if (out_tag !== 5'd7) begin failures++; $display("FAIL post_flush_tag got=%0d exp=7", out_tag); end
        step();
    endtask

    task automatic test_edge_cases();
        logic [2:0]  ops [12] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111,
                                  3'b010, 3'b011, 3'b011, 3'b100, 3'b101, 3'b000};
        logic [31:0] ins [12] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7FFF_FFFF,
                                  32'h8000_0000, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [4:0]  shs [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd9, 5'd31, 5'd31,
                                  5'd8, 5'd4, 5'd16};
        logic [31:0] exp [12] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000,
                                  32'hFFFF_FFFF, 32'h3456_7812, 32'h8123_4567, 32'hBEEF_0000};
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_one(ops[i], ins[i], shs[i], 5'(i + 1), res, rtag, lat);
            checks++; if (lat !== STAGES - 1) begin failures++; $display("FAIL edge_latency case=%0d got=%0d exp=%0d", i, lat, STAGES - 1); end
            checks++; if (res !== exp[i]) begin failures++; $display("FAIL edge_data case=%0d got=%h exp=%h", i, res, exp[i]); end
            checks++; if (rtag !== 5'(i + 1)) begin failures++; $display("FAIL edge_tag case=%0d got=%0d exp=%0d", i, rtag, i + 1); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  opset [7] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b111};
        logic [36:0] q[$];
        logic [36:0] e;
        int          mism = 0;
        for (int c = 0; c < 620; c++) begin
            if (c < 600) begin
                drive(opset[$urandom_range(6)], $urandom, 5'($urandom_range(31)), 5'($urandom_range(31)));
                in_valid  = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (in_valid && in_ready) q.push_back({in_tag, model(in_op, in_data, in_shamt)});
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; mism++;
                    $display("FAIL rand_extra got=%h/%0d exp=none", out_data, out_tag);
                end else begin
                    e = q.pop_front();
                    if ({out_tag, out_data} !== e) begin
                        failures++; mism++;
                        if (mism < 10) $display("FAIL rand_result got=%h/%0d exp=%h/%0d", out_data, out_tag, e[31:0], e[36:32]);
                    end
                end
            end
            step();
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_drain left=%0d exp=0", q.size()); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(3'b000, 32'h0000_00FF, 5'd4, 5'd9);
        step();
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_valid cyc=%0d got=%b exp=0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_sra_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_edge_cases();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor of the execute-stage combinational shifter.
- Performs logical left, logical right, arithmetic right, rotate-left and rotate-right on an XLEN-bit operand.
- The log2(XLEN) shift levels are spread across STAGES register stages, with valid/ready flow control and a sideband tag.
- Sits in the execute cluster between issue and writeback.

Parameters:
XLEN, 32, operand width; power of two, 8..64
STAGES, 2, register stages; 1..log2(XLEN); equals latency in cycles
TAG_W, 5, width of sideband tag (destination register index) carried with each operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight operations
in_valid  input  1  operation presented
in_ready  output  1  block accepts operation this cycle
in_data  input  XLEN  operand
in_shamt  input  log2(XLEN)  shift amount
in_op  input  3  000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR, others reserved
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  XLEN  result
out_tag  output  TAG_W  tag of result

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, out_data and out_tag are 0.
- in_ready is 0 while rst_n is low.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages, when there is no backpressure.
- Pipeline flow:
  - Each stage k holds valid_k, data, shamt remainder, op and tag.
  - Stage k loads when it is empty or when stage k+1 loads / the output transfers this cycle.
  - in_ready = !valid_0 || stage 0 advancing. This is combinational from out_ready; there are no bubbles.
  - Full throughput: one operation per cycle while out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, out_data and out_tag hold stable. Upstream stages fill; in_ready drops once all STAGES slots are valid.
- Shift arithmetic:
  - The shift amount is used modulo XLEN, since the port is exactly log2(XLEN) bits.
  - SLL zero-fills from the LSB. SRL zero-fills from the MSB. SRA replicates the original in_data[XLEN-1] from the MSB side.
  - ROL/ROR wrap bits around; shamt=0 yields in_data unchanged for every op.
  - Reserved op codes pass in_data through unchanged.
- Level distribution: level j (shift by 2^j) is placed in stage floor(j*STAGES/log2(XLEN)), with right/left direction fixed per op. The result is bit-identical to a single-cycle shifter; only timing differs.
- Flush:
  - On a clk edge with flush=1, all valid bits including out_valid clear. in_ready is forced 0 in that cycle, so no operation is accepted.
  - Data registers need not clear.
  - flush has priority over simultaneous input/output transfers; a result presented in the flush cycle with out_ready=1 still counts as transferred.
- Reset mid-operation: every in-flight operation is discarded immediately; nothing is emitted after release.
- Ordering: results leave strictly in acceptance order, each with its own tag.

Test Plan:
- Reset, then SRA in_data=0x8000_0000, shamt=4, tag=3, out_ready=1 -> two cycles later out_data=0xF800_0000, out_tag=3, out_valid high for exactly 1 cycle.
- Back-to-back ops, one per cycle, out_ready=1:
  - SLL 0x0000_0001 sh31 -> 0x8000_0000
  - SRL 0x8000_0000 sh31 -> 0x0000_0001
  - ROL 0x8000_0001 sh1 -> 0x0000_0003
  - ROR 0x0000_0001 sh1 -> 0x8000_0000
  - Results arrive on consecutive cycles in order with matching tags.
- Backpressure: hold out_ready=0 while issuing 3 ops -> in_ready drops after 2 accepts (STAGES=2); out_data is stable. Release -> remaining results drain in order with no loss or duplication.
- Flush with 2 in flight -> out_valid stays 0 for the following 3 cycles. A new op after flush (SRL 0xFFFF_FFFF sh8) -> 0x00FF_FFFF.
- Edge cases:
  - shamt=0 for all five ops on 0xDEAD_BEEF -> 0xDEAD_BEEF.
  - Reserved op 111 -> pass-through.
  - SRA 0x7FFF_FFFF sh31 -> 0x0000_0000.
- Parameter sweep XLEN=8/STAGES=1, XLEN=32/STAGES=5, XLEN=64/STAGES=3: 10k random ops against a reference model with random out_ready -> zero mismatches; latency equals STAGES when unstalled. Assert rst_n mid-stream -> out_valid drops asynchronously.
